// File: rtl/sobel_edge_stage_pkg.sv
// Shared widths, window types and helpers for the Sobel edge stage.
// A window is unpacked so that p[r][c] has row 0 oldest and column 0 oldest.
package sobel_pkg;

    localparam int WIN_W  = 72;
    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [2:0][2:0]  win_t;

    function automatic win_t unpack_win(input logic [WIN_W-1:0] d);
        win_t w;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[r][c] = d[(2-r)*24 + (2-c)*8 +: PIX_W];
            end
        end
        return w;
    endfunction

    function automatic logic signed [GRAD_W-1:0] ext(input pix_t v);
        return $signed({{(GRAD_W-PIX_W){1'b0}}, v});
    endfunction

endpackage

// File: rtl/sobel_edge_stage_if.sv
// AXI4-Stream style bundle used for both the window input and the pixel output.
interface sobel_axis_if #(parameter int W = 24) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tuser;
    logic         tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/sobel_edge_stage_kernel.sv
// Sobel arithmetic: stage 1 registers Gx/Gy, stage 2 registers |Gx|+|Gy|.
module sobel_kernel
    import sobel_pkg::*;
(
    input  logic             aclk,
    input  logic             en,
    input  logic [WIN_W-1:0] win,
    output logic [MAG_W-1:0] mag
);
    win_t                     p;
    logic signed [GRAD_W-1:0] gx_c;
    logic signed [GRAD_W-1:0] gy_c;
    logic signed [GRAD_W-1:0] gx;
    logic signed [GRAD_W-1:0] gy;
    logic        [MAG_W-1:0]  ax;
    logic        [MAG_W-1:0]  ay;

    // Partial sums never exceed 1020, so 11-bit signed holds every intermediate.
    always_comb begin
        p    = unpack_win(win);
        gx_c = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
             - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
        gy_c = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
             - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
    end

    assign ax = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    assign ay = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);

    always_ff @(posedge aclk) begin
        if (en) begin
            gx  <= gx_c;
            gy  <= gy_c;
            mag <= ax + ay;
        end
    end
endmodule

// File: rtl/sobel_edge_stage.sv
// Sobel edge stage: 3-deep pipeline with shared stall, coordinate tracking,
// border masking, threshold/grey output and line-length checking.
module sobel_edge_stage
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int THRESHOLD  = 100,
    parameter int BINARY_OUT = 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    sobel_axis_if.slave   s_axis,
    sobel_axis_if.master  m_axis,
    output logic          line_len_err
);
    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

    logic          en;
    logic          accept;
    logic          synced;
    logic [CW-1:0] col, bcol, ncol;
    logic [RW-1:0] row, brow, nrow;
    logic          border_c, err_c;
    logic          v1, u1, l1, e1, b1;
    logic          v2, u2, l2, e2, b2;
    logic [MAG_W-1:0] mag;
    logic [PIX_W-1:0] pix;

    assign en            = ~m_axis.tvalid | m_axis.tready;
    assign s_axis.tready = en;
    assign accept        = s_axis.tvalid & en;

    sobel_kernel u_kernel (
        .aclk (aclk),
        .en   (en),
        .win  (s_axis.tdata),
        .mag  (mag)
    );

    // bcol/brow are the coordinates of the beat on the input; col/row hold the next beat's.
    always_comb begin
        bcol = s_axis.tuser ? '0 : col;
        brow = s_axis.tuser ? '0 : row;
        ncol = bcol;
        nrow = brow;
        if (s_axis.tlast) begin
            ncol = '0;
            nrow = (brow == RW'(IMG_HEIGHT-1)) ? brow : brow + RW'(1);
        end else begin
            ncol = (bcol == CW'(IMG_WIDTH-1)) ? bcol : bcol + CW'(1);
        end
        border_c = (bcol < CW'(2)) | (brow < RW'(2));
        err_c    = s_axis.tlast ? (bcol != CW'(IMG_WIDTH-1)) : (bcol == CW'(IMG_WIDTH-1));
    end

    always_comb begin
        pix = (mag > MAG_W'(255)) ? 8'hFF : mag[PIX_W-1:0];
        if (BINARY_OUT != 0) begin
            pix = (mag >= MAG_W'(THRESHOLD)) ? 8'hFF : 8'h00;
        end
        if (b2) begin
            pix = '0;
        end
    end

    // Beats arriving before the first start-of-frame after reset are swallowed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            col           <= '0;
            row           <= '0;
            synced        <= 1'b0;
            {v1, u1, l1, e1, b1} <= '0;
            {v2, u2, l2, e2, b2} <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_axis.tdata  <= '0;
            line_len_err  <= 1'b0;
        end else begin
            if (accept) begin
                col <= ncol;
                row <= nrow;
                if (s_axis.tuser) begin
                    synced <= 1'b1;
                end
            end
            line_len_err <= en & v2 & e2;
            if (en) begin
                v1 <= s_axis.tvalid & (s_axis.tuser | synced);
                u1 <= s_axis.tuser;
                l1 <= s_axis.tlast;
                e1 <= err_c;
                b1 <= border_c;
                {v2, u2, l2, e2, b2} <= {v1, u1, l1, e1, b1};
                m_axis.tvalid <= v2;
                m_axis.tuser  <= u2;
                m_axis.tlast  <= l2;
                m_axis.tdata  <= {3{pix}};
            end
        end
    end
endmodule

// File: tb/tb_sobel_edge_stage.sv
// Bench for sobel_edge_stage: two instances (binary and grey) on one stimulus
// stream, scored against an arithmetic reference model through per-lane queues.
module tb_sobel_edge_stage;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int THR = 100;

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [71:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_user = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;
    logic        ready_rand = 1'b0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_pulses = 0;
    int   acc_cyc = 0;
    int   mcol = 0;
    int   mrow = 0;
    bit   synced = 1'b0;
    exp_t exp_q[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (ready_rand) m_ready = ($urandom_range(0, 3) != 0);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        sobel_axis_if #(.W(72)) s_if ();
        sobel_axis_if #(.W(24)) m_if ();
        logic        err;
        logic        stalled = 1'b0;
        logic [23:0] hold_data = '0;
        logic        hold_user = 1'b0;
        logic        hold_last = 1'b0;
        exp_t        e;

        assign s_if.tdata  = s_data;
        assign s_if.tvalid = s_valid;
        assign s_if.tuser  = s_user;
        assign s_if.tlast  = s_last;
        assign m_if.tready = m_ready;

        sobel_edge_stage #(
            .IMG_WIDTH (W),
            .IMG_HEIGHT(H),
            .THRESHOLD (THR),
            .BINARY_OUT((g == 0) ? 1 : 0)
        ) dut (
            .aclk        (clk),
            .aresetn     (rst_n),
            .s_axis      (s_if),
            .m_axis      (m_if),
            .line_len_err(err)
        );

        always @(negedge clk) begin
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk($sformatf("lane%0d hold_valid", g), 32'(m_if.tvalid), 32'd1);
                    chk($sformatf("lane%0d hold_data", g), 32'(m_if.tdata), 32'(hold_data));
                    chk($sformatf("lane%0d hold_user", g), 32'(m_if.tuser), 32'(hold_user));
                    chk($sformatf("lane%0d hold_last", g), 32'(m_if.tlast), 32'(hold_last));
                end
                if (m_if.tvalid && !stalled) begin
                    if (exp_q[g].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL lane%0d unexpected_beat got %h want no beat", g, m_if.tdata);
                    end else begin
                        chk($sformatf("lane%0d line_len_err", g), 32'(err), 32'(exp_q[g][0].err));
                    end
                end else begin
                    chk($sformatf("lane%0d line_len_err_idle", g), 32'(err), 32'd0);
                end
                if (m_if.tvalid && m_ready && exp_q[g].size() != 0) begin
                    e = exp_q[g].pop_front();
                    chk($sformatf("lane%0d tdata", g), 32'(m_if.tdata), 32'(e.data));
                    chk($sformatf("lane%0d tuser", g), 32'(m_if.tuser), 32'(e.user));
                    chk($sformatf("lane%0d tlast", g), 32'(m_if.tlast), 32'(e.last));
                end
                if (g == 0 && err === 1'b1) err_pulses++;
                stalled   = m_if.tvalid && !m_ready;
                hold_data = m_if.tdata;
                hold_user = m_if.tuser;
                hold_last = m_if.tlast;
            end
        end
    end

    task automatic model_accept(input logic [71:0] d, input logic u, input logic l);
        int   p[3][3];
        int   gx, gy, mag, c, r, bin, grey;
        exp_t e;
        c = u ? 0 : mcol;
        r = u ? 0 : mrow;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                p[rr][cc] = int'(d[(2-rr)*24 + (2-cc)*8 +: 8]);
        gx   = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy   = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        mag  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        bin  = (mag >= THR) ? 255 : 0;
        grey = (mag > 255) ? 255 : mag;
        if (c < 2 || r < 2) begin
            bin  = 0;
            grey = 0;
        end
        e.user = u;
        e.last = l;
        e.err  = l ? (c != W-1) : (c == W-1);
        if (u) synced = 1'b1;
        if (synced) begin
            e.data = {3{8'(bin)}};
            exp_q[0].push_back(e);
            e.data = {3{8'(grey)}};
            exp_q[1].push_back(e);
        end
        if (l) begin
            mcol = 0;
            mrow = (r + 1 > H - 1) ? H - 1 : r + 1;
        end else begin
            mcol = (c + 1 > W - 1) ? W - 1 : c + 1;
            mrow = r;
        end
    endtask

    task automatic send(input logic [71:0] d, input logic u, input logic l);
        int t = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        s_user  = u;
        s_last  = l;
        #1;
        while (lane[0].s_if.tready !== 1'b1) begin
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout got no s_axis_tready want accept within 200 cycles");
                break;
            end
            @(negedge clk);
            #1;
        end
        acc_cyc = cyc;
        model_accept(d, u, l);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    function automatic logic [71:0] rand_win();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    function automatic logic [71:0] dir_win(input int r, input int c, input logic [71:0] dflt);
        if (r == 2 && c == 2) return {9{8'h80}};
        if ((r == 2 && c == 3) || (r == 3 && c == 5) || (r == 1 && c == 5)) return {3{24'h0080FF}};
        if (r == 2 && c == 4) return {3{24'h000810}};
        return dflt;
    endfunction

    task automatic drain();
        int t = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        mcol   = 0;
        mrow   = 0;
        synced = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #3;
        chk("rst lane0 tvalid", 32'(lane[0].m_if.tvalid), 32'd0);
        chk("rst lane1 tvalid", 32'(lane[1].m_if.tvalid), 32'd0);
        chk("rst lane0 tdata", 32'(lane[0].m_if.tdata), 32'd0);
        chk("rst lane0 tuser", 32'(lane[0].m_if.tuser), 32'd0);
        chk("rst lane0 tlast", 32'(lane[0].m_if.tlast), 32'd0);
        chk("rst lane0 err", 32'(lane[0].err), 32'd0);
        chk("rst lane0 col", 32'(lane[0].dut.col), 32'd0);
        chk("rst lane0 row", 32'(lane[0].dut.row), 32'd0);
        chk("rst lane0 s_tready", 32'(lane[0].s_if.tready), 32'd1);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input bit directed, input bit gaps);
        for (int r = 0; r < nlines; r++) begin
            int len;
            len = (r == bad_line) ? bad_len : W;
            for (int c = 0; c < len; c++) begin
                logic [71:0] d;
                d = rand_win();
                if (directed) d = dir_win(r, c, d);
                if (gaps) repeat (int'($urandom_range(0, 1))) @(negedge clk);
                if (directed && r == 2 && c == 2) begin
                    int t;
                    repeat (5) @(negedge clk);
                    send(d, 1'b0, 1'b0);
                    for (t = 0; t < 10; t++) begin
                        @(negedge clk);
                        #3;
                        if (lane[0].m_if.tvalid === 1'b1) break;
                    end
                    chk("latency_cycles", 32'(cyc - acc_cyc), 32'd3);
                end else begin
                    send(d, (r == 0 && c == 0), (c == len - 1));
                end
            end
        end
    endtask

    initial begin
        apply_reset();

        err_pulses = 0;
        send_frame(4, -1, W, 1'b1, 1'b0);
        drain();
        chk("err_pulses_good_frame", 32'(err_pulses), 32'd0);

        err_pulses = 0;
        send_frame(4, 1, 7, 1'b1, 1'b0);
        drain();
        chk("err_pulses_short_line", 32'(err_pulses), 32'd1);

        fork
            for (int i = 0; i < 10; i++) send(rand_win(), (i == 0), (i == 7));
            begin
                repeat (4) @(negedge clk);
                m_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    #1;
                    chk("stall s_tready lane0", 32'(lane[0].s_if.tready), 32'd0);
                    chk("stall s_tready lane1", 32'(lane[1].s_if.tready), 32'd0);
                end
                @(negedge clk);
                m_ready = 1'b1;
            end
        join
        drain();

        send(rand_win(), 1'b1, 1'b0);
        drain();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_win(), 1'b0, 1'b0);
        apply_reset();
        for (int i = 0; i < 4; i++) send(rand_win(), 1'b0, (i == 3));
        repeat (8) @(negedge clk);
        send_frame(2, -1, W, 1'b0, 1'b0);
        drain();

        ready_rand = 1'b1;
        send_frame(4, -1, W, 1'b0, 1'b1);
        send_frame(5, 2, 9, 1'b0, 1'b1);
        send_frame(4, 3, 7, 1'b0, 1'b1);
        send_frame(4, -1, W, 1'b1, 1'b1);
        drain();
        ready_rand = 1'b0;
        m_ready    = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_edge_stage.md
Name: sobel_edge_stage

Overview:
- Consumes the 72-bit 3x3 window AXI4-Stream produced by the line-buffer stage. Produces one 24-bit RGB edge pixel per accepted window.
- Computes the Sobel gradient magnitude, then thresholds it or passes it through as grey.
- Runs a 3-stage pipeline with full valid/ready backpressure.
- Tracks column and row so that border windows, where the window is not yet populated, output black.

Parameters:
- IMG_WIDTH, 640: pixels per line; sets the column counter range.
- IMG_HEIGHT, 480: lines per frame; sets the row counter range.
- THRESHOLD, 100: magnitude at or above this value is an edge (binary mode only).
- BINARY_OUT, 1: 1 outputs 0x00/0xFF only; 0 outputs the saturated magnitude as grey.

Ports:
- aclk, in, 1: clock; all logic rises on this edge.
- aresetn, in, 1: reset, synchronous, active-low.
- s_axis_tdata, in, 72: 3x3 window. Bits [23:0] are the newest row (r2), [47:24] the middle row (r1), [71:48] the oldest row (r0). Within each row, [7:0] is the newest column (c2), [15:8] is c1, [23:16] is c0.
- s_axis_tvalid, in, 1: input window valid.
- s_axis_tready, out, 1: block accepts a window.
- s_axis_tuser, in, 1: start of frame (first window of the frame).
- s_axis_tlast, in, 1: end of line.
- m_axis_tdata, out, 24: edge pixel with the same 8-bit value replicated on R, G and B.
- m_axis_tvalid, out, 1: output valid.
- m_axis_tready, in, 1: downstream ready.
- m_axis_tuser, out, 1: start of frame, aligned with its pixel.
- m_axis_tlast, out, 1: end of line, aligned with its pixel.
- line_len_err, out, 1: one-cycle pulse when a line is not IMG_WIDTH beats long.

Behaviour:
- Reset (aresetn=0 at the clock edge):
  - All stage valid bits, m_axis_tvalid, m_axis_tuser, m_axis_tlast and line_len_err clear to 0.
  - m_axis_tdata clears to 0.
  - col and row counters clear to 0.
  - Reset mid-frame discards every in-flight beat. Output resumes only after the next s_axis_tuser.
- Handshake and stall:
  - Pipeline enable: en = ~m_axis_tvalid | m_axis_tready.
  - s_axis_tready = en, purely combinational from the output register.
  - When en=1, every stage advances together and the stage-1 valid bit loads s_axis_tvalid.
  - When en=0, all stages hold their data and valid bits. m_axis_* stays stable while m_axis_tvalid=1 and m_axis_tready=0.
  - No beat is dropped or duplicated.
- Latency: an accepted window appears on m_axis exactly 3 cycles later when m_axis_tready is held at 1. Throughput is 1 beat per cycle.
- Sideband: tuser and tlast travel through the pipeline with their data.
- Counters (update on an accepted beat, i.e. s_axis_tvalid & s_axis_tready):
  - tuser=1 forces the beat's coordinates to col=0, row=0.
  - tlast=1: next col=0 and row increments, saturating at IMG_HEIGHT-1.
  - Otherwise col increments, saturating at IMG_WIDTH-1.
  - line_len_err pulses, aligned with output, when tlast arrives with col != IMG_WIDTH-1, or when a beat arrives with col already at IMG_WIDTH-1 and tlast=0.
- Border mask: a beat with col<2 or row<2 outputs 0x000000. Its sideband bits are unchanged.
- Stage 1, gradients. Notation p[r][c]; all values 11-bit signed, range ±1020.
  - Gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]).
  - Gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]).
- Stage 2, magnitude: mag = |Gx| + |Gy|, 11-bit unsigned, maximum 2040. Register the border flag alongside it.
- Stage 3, output:
  - sat = min(mag, 255).
  - BINARY_OUT=1: value = (mag >= THRESHOLD) ? 0xFF : 0x00. The comparison uses the unsaturated mag.
  - BINARY_OUT=0: value = sat.
  - A set border flag forces value to 0.
- Simultaneous tuser and tlast on one beat: the tuser reset applies first, then the tlast rule applies (next col=0, row=1).

Decomposition:
- Package sobel_pkg:
  - WIN_W=72, PIX_W=8, GRAD_W=11 (signed), MAG_W=11.
  - Window-unpack function taking 72 bits to p[r][c].
- One sub-module, sobel_kernel: combinational/registered Gx, Gy and mag arithmetic with an enable input. Parent sobel_edge_stage owns the handshake, counters, sideband pipeline and output stage.

Test Plan:
- Uniform window, all pixels 0x80, at col=5, row=5 -> Gx=Gy=0 -> m_axis_tdata=0x000000 exactly 3 cycles after acceptance.
- Vertical edge, c0=0x00 and c2=0xFF in every row -> Gx=1020, mag=1020 -> 0xFFFFFF. With BINARY_OUT=0 -> 0xFFFFFF (sat 255).
- Weak gradient, c0=0x00 and c2=0x10 -> Gx=64 < 100 -> 0x000000. With BINARY_OUT=0 -> 0x404040.
- Stream 10 beats, drop m_axis_tready for 5 cycles mid-stream -> s_axis_tready=0 during the stall, m_axis_* held stable, all 10 outputs in order with no loss.
- Frame of IMG_WIDTH=8, IMG_HEIGHT=4 with tuser on the first beat and tlast every 8th beat -> outputs on rows 0-1 and columns 0-1 are 0, tuser and tlast appear at output positions 1 and 8/16/24/32, line_len_err never pulses. Repeat with a 7-beat line -> a single line_len_err pulse.
- Assert aresetn=0 for 1 cycle mid-frame with 3 beats in flight -> m_axis_tvalid=0 on the next cycle, counters at 0, and none of the in-flight beats is ever output.
